mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Load/store access controller between the execute/memory pipeline stage and a multi-cycle data memory. Accepts one load or store request at a time, drives the word-aligned memory bus with byte enables and lane-replicated write data, waits on the memory ready handshake with a timeout, and returns the raw read word plus offset/size/extension tags to the downstream read-data decoder (big-endian lane order: offset 0 = bits 31:24).

## Interface
- TIMEOUT_CYCLES, 16, max cycles memEn is held without memReady before bus error (≥2)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- reqValid  in  1  request present (sampled in IDLE only)
- reqWrite  in  1  1 = store, 0 = load
- reqAddr  in  32  byte address
- reqWData  in  32  store data, right-justified
- reqSize  in  2  00 word, 01 half, 10 byte, 11 reserved
- reqExt  in  1  sign-extend flag, forwarded to decoder
- reqBusy  out  1  stall to pipeline; high whenever state ≠ IDLE
- memEn  out  1  memory access strobe
- memWrite  out  1  1 = write cycle
- memAddr  out  32  {reqAddr[31:2], 2'b00}
- memWData  out  32  lane-replicated store data
- memBE  out  4  byte enables, bit3 = bits 31:24
- memRData  in  32  read word
- memReady  in  1  access complete, sampled while memEn high
- rspValid  out  1  one-cycle response pulse
- rspErr  out  1  valid with rspValid: timeout or misalignment
- rspRData  out  32  raw captured word (decoder dIn); 0 for stores/errors
- rspOffset, rspSize, rspExt  out  2/2/1  latched reqAddr[1:0], reqSize, reqExt (decoder offset/dSize/dExt)

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: reqValid=1 → latch request, compute memBE/memWData; → ACCESS (or RESP with rspErr if misaligned, see Configuration).
- ACCESS: memEn=1, memWrite/memAddr/memBE/memWData stable. memReady=1 → capture memRData (loads), → RESP. Timeout counter increments each ACCESS cycle; reaching TIMEOUT_CYCLES without memReady → rspErr=1, → RESP. memReady on the timeout cycle wins (no error).
- RESP: rspValid=1 for exactly one cycle → IDLE.
- Byte enables / write data: word → 1111, data as-is. Half offset[1]=0 → 1100, offset[1]=1 → 0011, data {wd[15:0],wd[15:0]}. Byte offset n → one-hot bit (3−n), data = wd[7:0] replicated 4×. Loads drive memBE=1111, memWData=0.
- rsp* tag outputs hold their value from latch until next accepted request.

## Timing
- Reset (async): state IDLE, counter 0, all outputs 0.
- Accept at edge 0 → memEn high from cycle 1. memReady high in cycle k → rspValid in cycle k+1. Minimum request-to-response: 2 cycles.
- reqValid in ACCESS/RESP is ignored; pipeline must hold it while reqBusy=1. Back-to-back: new request accepted the cycle after RESP.
- memEn drops the cycle after memReady or timeout; no request is reissued.
- rst mid-ACCESS: memEn drops immediately, no rspValid for the aborted request.

## Configuration
- MEM_MISALIGN_EXC_EN defined: word with offset≠00, half with offset[0]=1, or reqSize=11 → no memory access, IDLE→RESP directly, rspErr=1, rspRData=0.
- Undefined: no check; reqSize=11 treated as word; half uses offset[1] only; access always performed.

## Structure
- Package mem_pkg: reqSize encodings (SIZE_WORD/HALF/BYTE/RSVD), state enum, BE constants.
- Sub-module mem_wdata_encoder (combinational): offset, size, wdata → memBE, memWData.

## Test plan
- Load word addr 0x100, memReady in 3rd ACCESS cycle, memRData 0xAABBCCDD → rspValid cycle 4 after accept, rspRData 0xAABBCCDD, rspOffset 00, rspSize 00, rspErr 0.
- Store byte addr 0x103, wdata 0x12345678 → memAddr 0x100, memBE 0001, memWData 0x78787878, memWrite 1.
- Store half addr 0x202, wdata 0x0000BEEF → memBE 0011, memWData 0xBEEFBEEF.
- memReady held low → memEn high exactly TIMEOUT_CYCLES cycles, then rspValid with rspErr 1, rspRData 0.
- With MEM_MISALIGN_EXC_EN, load word addr 0x101 → memEn never asserts, rspValid next cycle with rspErr 1; without macro, access occurs with rspOffset 01.
- rst asserted mid-ACCESS → memEn, reqBusy 0 immediately; next request completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the load/store access controller: request sizes,
// controller states and byte-enable patterns (big-endian lanes, bit3 = bits 31:24).
package mem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic [3:0] BE_ALL     = 4'b1111;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_BYTE0   = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Misaligned: word off the word boundary, half on an odd byte, or reserved size.
  function automatic logic is_misaligned(input logic [1:0] offset, input logic [1:0] size);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_WORD: bad = (offset != 2'b00);
      SIZE_HALF: bad = offset[0];
      SIZE_BYTE: bad = 1'b0;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_wdata_encoder.sv
// Store lane encoder: turns (offset, size, right-justified data) into byte
// enables and lane-replicated write data. Reserved size encodes as a word.
module mem_wdata_encoder
  import mem_pkg::*;
(
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata
);

  always_comb begin
    // NOTE: defaults assigned first so every path drives both outputs; no latch.
    o_be    = BE_ALL;
    o_wdata = i_wdata;
    case (i_size)
      SIZE_HALF: begin
        o_be    = i_offset[1] ? BE_LO_HALF : BE_HI_HALF;
        o_wdata = {2{i_wdata[15:0]}};
      end
      SIZE_BYTE: begin
        o_be    = BE_BYTE0 >> i_offset;
        o_wdata = {4{i_wdata[7:0]}};
      end
      default: begin
        o_be    = BE_ALL;
        o_wdata = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store access controller: one request at a time to a multi-cycle memory,
// with ready timeout. Optional MEM_MISALIGN_EXC_EN rejects misaligned requests.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  input  logic        reqWrite,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  input  logic [1:0]  reqSize,
  input  logic        reqExt,
  output logic        reqBusy,
  output logic        memEn,
  output logic        memWrite,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic [3:0]  memBE,
  input  logic [31:0] memRData,
  input  logic        memReady,
  output logic        rspValid,
  output logic        rspErr,
  output logic [31:0] rspRData,
  output logic [1:0]  rspOffset,
  output logic [1:0]  rspSize,
  output logic        rspExt
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_en;
  logic             r_mem_write;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [3:0]       r_mem_be;
  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic [31:0]      r_rsp_rdata;
  logic [1:0]       r_rsp_offset;
  logic [1:0]       r_rsp_size;
  logic             r_rsp_ext;

  logic [3:0]       w_enc_be;
  logic [31:0]      w_enc_wdata;
  logic             w_misaligned;

  mem_wdata_encoder u_enc (
    .i_offset (reqAddr[1:0]),
    .i_size   (reqSize),
    .i_wdata  (reqWData),
    .o_be     (w_enc_be),
    .o_wdata  (w_enc_wdata)
  );

`ifdef MEM_MISALIGN_EXC_EN
  assign w_misaligned = is_misaligned(reqAddr[1:0], reqSize);
`else
  assign w_misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_mem_en     <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_offset <= '0;
      r_rsp_size   <= '0;
      r_rsp_ext    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; every register reads pre-edge values.
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (reqValid) begin
            r_rsp_offset <= reqAddr[1:0];
            r_rsp_size   <= reqSize;
            r_rsp_ext    <= reqExt;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_cnt        <= '0;
            if (w_misaligned) begin
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              r_mem_en    <= 1'b1;
              r_mem_write <= reqWrite;
              r_mem_addr  <= {reqAddr[31:2], 2'b00};
              r_mem_be    <= reqWrite ? w_enc_be : BE_ALL;
              r_mem_wdata <= reqWrite ? w_enc_wdata : 32'h0;
              r_state     <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // Ready on the final allowed cycle still completes without error.
          if (memReady) begin
            r_mem_en    <= 1'b0;
            r_rsp_valid <= 1'b1;
            if (!r_mem_write) r_rsp_rdata <= memRData;
            r_state     <= ST_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_mem_en    <= 1'b0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign reqBusy   = (r_state != ST_IDLE);
  assign memEn     = r_mem_en;
  assign memWrite  = r_mem_write;
  assign memAddr   = r_mem_addr;
  assign memWData  = r_mem_wdata;
  assign memBE     = r_mem_be;
  assign rspValid  = r_rsp_valid;
  assign rspErr    = r_rsp_err;
  assign rspRData  = r_rsp_rdata;
  assign rspOffset = r_rsp_offset;
  assign rspSize   = r_rsp_size;
  assign rspExt    = r_rsp_ext;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, hand-written
// back-to-back and reset sequences, then random requests against a lane model.
module tb_mem_access_ctrl;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid, reqWrite, reqExt, memReady;
  logic [31:0] reqAddr, reqWData, memRData;
  logic [1:0]  reqSize;
  logic        reqBusy, memEn, memWrite, rspValid, rspErr, rspExt;
  logic [31:0] memAddr, memWData, rspRData;
  logic [3:0]  memBE;
  logic [1:0]  rspOffset, rspSize;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr), .reqWData(reqWData),
    .reqSize(reqSize), .reqExt(reqExt), .reqBusy(reqBusy),
    .memEn(memEn), .memWrite(memWrite), .memAddr(memAddr), .memWData(memWData),
    .memBE(memBE), .memRData(memRData), .memReady(memReady),
    .rspValid(rspValid), .rspErr(rspErr), .rspRData(rspRData),
    .rspOffset(rspOffset), .rspSize(rspSize), .rspExt(rspExt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic        ext;
    int          lat;   // ACCESS cycle in which ready is given; 0 = never
    logic [31:0] rd;
  } req_t;

  typedef struct {
    int          en;    // cycles memEn is high
    logic        err;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    req_t req;
    exp_t exp;
  } vec_t;

  typedef struct {
    bit          got;
    int          en;
    int          rsp_cyc;
    bit          stable;
    bit          busy_ok;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [3:0]  mbe;
    logic        mwr;
    logic [1:0]  off;
    logic [1:0]  sz;
    logic        ext;
  } obs_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic req_t mk_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [1:0] sz, input logic ext, input int lat,
                                  input logic [31:0] rd);
    req_t r;
    r.wr = wr; r.addr = addr; r.wd = wd; r.sz = sz; r.ext = ext; r.lat = lat; r.rd = rd;
    return r;
  endfunction

  function automatic exp_t mk_exp(input int en, input logic err, input logic [3:0] be,
                                  input logic [31:0] wdata, input logic [31:0] rdata);
    exp_t e;
    e.en = en; e.err = err; e.be = be; e.wdata = wdata; e.rdata = rdata;
    return e;
  endfunction

  // Reference model: the access touches a run of bytes in big-endian lane order;
  // each lane carries the data byte at its position within the access size.
  function automatic exp_t model(input req_t r);
    exp_t e;
    int   nbytes, start, j;
    bit   mis, timed;
    nbytes = (r.sz == 2'b01) ? 2 : (r.sz == 2'b10) ? 1 : 4;
    start  = (nbytes == 4) ? 0 : (nbytes == 2) ? 2 * int'(r.addr[1]) : int'(r.addr[1:0]);
    mis    = 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
    mis = (r.sz == 2'b11) || (nbytes == 4 && r.addr[1:0] != 2'b00) || (nbytes == 2 && r.addr[0]);
`endif
    e.be    = 4'b0000;
    e.wdata = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (b >= start && b < start + nbytes) e.be[3-b] = 1'b1;
      j = b % nbytes;
      e.wdata[31-8*b -: 8] = r.wd[8*(nbytes-1-j) +: 8];
    end
    if (!r.wr) begin
      e.be    = 4'b1111;
      e.wdata = 32'h0;
    end
    timed   = !(r.lat >= 1 && r.lat <= T);
    e.en    = mis ? 0 : (timed ? T : r.lat);
    e.err   = mis || timed;
    e.rdata = (!r.wr && !e.err) ? r.rd : 32'h0;
    return e;
  endfunction

  task automatic run_txn(input req_t r, output obs_t o);
    o = '{default: '0};
    o.stable  = 1'b1;
    o.busy_ok = 1'b1;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = r.wr; reqAddr = r.addr; reqWData = r.wd;
    reqSize = r.sz; reqExt = r.ext; memRData = r.rd; memReady = 1'b0;
    @(negedge clk);
    reqValid = 1'b0;
    for (int cyc = 1; cyc <= T + 8; cyc++) begin
      if (!reqBusy) o.busy_ok = 1'b0;
      if (memEn) begin
        if (o.en == 0) begin
          o.maddr = memAddr; o.mbe = memBE; o.mwd = memWData; o.mwr = memWrite;
        end else if (memAddr !== o.maddr || memBE !== o.mbe || memWData !== o.mwd || memWrite !== o.mwr) begin
          o.stable = 1'b0;
        end
        o.en++;
      end
      if (rspValid) begin
        o.got = 1'b1; o.rsp_cyc = cyc; o.err = rspErr; o.rdata = rspRData;
        o.off = rspOffset; o.sz = rspSize; o.ext = rspExt;
        break;
      end
      memReady = memEn && (o.en == r.lat);
      @(negedge clk);
    end
    memReady = 1'b0;
  endtask

  task automatic compare_txn(input string tag, input req_t r, input exp_t e, input obs_t o);
    check({tag, "_rsp_seen"}, 32'(o.got), 32'd1);
    if (o.got) begin
      check({tag, "_memEn_cycles"}, o.en, e.en);
      check({tag, "_rsp_cycle"}, o.rsp_cyc, e.en + 1);
      check({tag, "_rspErr"}, 32'(o.err), 32'(e.err));
      check({tag, "_rspRData"}, o.rdata, e.rdata);
      check({tag, "_rspOffset"}, 32'(o.off), 32'(r.addr[1:0]));
      check({tag, "_rspSize"}, 32'(o.sz), 32'(r.sz));
      check({tag, "_rspExt"}, 32'(o.ext), 32'(r.ext));
      check({tag, "_busy"}, 32'(o.busy_ok), 32'd1);
      if (e.en > 0) begin
        check({tag, "_memAddr"}, o.maddr, {r.addr[31:2], 2'b00});
        check({tag, "_memBE"}, 32'(o.mbe), 32'(e.be));
        check({tag, "_memWData"}, o.mwd, e.wdata);
        check({tag, "_memWrite"}, 32'(o.mwr), 32'(r.wr));
        check({tag, "_stable"}, 32'(o.stable), 32'd1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  vec_t vecs[12];
  obs_t o;
  req_t r;
  int   seen;

  initial begin
    rst = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWData = '0;
    reqSize = '0; reqExt = 1'b0; memReady = 1'b0; memRData = '0;

    vecs[0].req  = mk_req(0, 32'h100, 32'h0, 2'b00, 0, 3, 32'hAABBCCDD);
    vecs[0].exp  = mk_exp(3, 0, 4'b1111, 32'h0, 32'hAABBCCDD);
    vecs[1].req  = mk_req(1, 32'h103, 32'h12345678, 2'b10, 0, 1, 32'h55555555);
    vecs[1].exp  = mk_exp(1, 0, 4'b0001, 32'h78787878, 32'h0);
    vecs[2].req  = mk_req(1, 32'h202, 32'h0000BEEF, 2'b01, 0, 2, 32'h0);
    vecs[2].exp  = mk_exp(2, 0, 4'b0011, 32'hBEEFBEEF, 32'h0);
    vecs[3].req  = mk_req(1, 32'h200, 32'h1234CAFE, 2'b01, 0, 1, 32'h0);
    vecs[3].exp  = mk_exp(1, 0, 4'b1100, 32'hCAFECAFE, 32'h0);
    vecs[4].req  = mk_req(1, 32'h101, 32'h000000AB, 2'b10, 0, 2, 32'h0);
    vecs[4].exp  = mk_exp(2, 0, 4'b0100, 32'hABABABAB, 32'h0);
    vecs[5].req  = mk_req(1, 32'h300, 32'hDEADBEEF, 2'b00, 0, 4, 32'h0);
    vecs[5].exp  = mk_exp(4, 0, 4'b1111, 32'hDEADBEEF, 32'h0);
    vecs[6].req  = mk_req(0, 32'h102, 32'h0, 2'b01, 1, 0, 32'h11112222);
    vecs[6].exp  = mk_exp(T, 1, 4'b1111, 32'h0, 32'h0);
    vecs[7].req  = mk_req(0, 32'h103, 32'h0, 2'b10, 1, T, 32'h87654321);
    vecs[7].exp  = mk_exp(T, 0, 4'b1111, 32'h0, 32'h87654321);
    vecs[8].req  = mk_req(0, 32'h101, 32'h0, 2'b00, 0, 1, 32'hCAFEF00D);
    vecs[9].req  = mk_req(1, 32'h100, 32'h11223344, 2'b11, 0, 1, 32'h0);
    vecs[10].req = mk_req(0, 32'h101, 32'h0, 2'b01, 1, 2, 32'h01020304);
`ifdef MEM_MISALIGN_EXC_EN
    vecs[8].exp  = mk_exp(0, 1, 4'b1111, 32'h0, 32'h0);
    vecs[9].exp  = mk_exp(0, 1, 4'b1111, 32'h0, 32'h0);
    vecs[10].exp = mk_exp(0, 1, 4'b1111, 32'h0, 32'h0);
`else
    vecs[8].exp  = mk_exp(1, 0, 4'b1111, 32'h0, 32'hCAFEF00D);
    vecs[9].exp  = mk_exp(1, 0, 4'b1111, 32'h11223344, 32'h0);
    vecs[10].exp = mk_exp(2, 0, 4'b1111, 32'h0, 32'h01020304);
`endif
    vecs[11].req = mk_req(0, 32'h102, 32'h0, 2'b10, 0, T + 1, 32'h5A5A5A5A);
    vecs[11].exp = mk_exp(T, 1, 4'b1111, 32'h0, 32'h0);

    // Reset state
    #12;
    check("reset_memEn", 32'(memEn), 32'd0);
    check("reset_reqBusy", 32'(reqBusy), 32'd0);
    check("reset_rspValid", 32'(rspValid), 32'd0);
    check("reset_bus", {memAddr[27:0], memBE}, 32'd0);
    check("reset_rsp", rspRData | memWData | {27'd0, rspErr, rspOffset, rspSize} | 32'(rspExt) | 32'(memWrite), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].req, o);
      compare_txn($sformatf("vec%0d", i), vecs[i].req, vecs[i].exp, o);
    end

    // Request held through busy is ignored, then accepted right after RESP.
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h400; reqSize = 2'b00; reqExt = 1'b0;
    memRData = 32'h0BADF00D;
    @(negedge clk);
    check("b2b_first_memEn", 32'(memEn), 32'd1);
    check("b2b_first_addr", memAddr, 32'h400);
    reqWrite = 1'b1; reqAddr = 32'h502; reqWData = 32'h00000099; memReady = 1'b1;
    @(negedge clk);
    memReady = 1'b0;
    check("b2b_first_rspValid", 32'(rspValid), 32'd1);
    check("b2b_first_rdata", rspRData, 32'h0BADF00D);
    check("b2b_resp_memEn", 32'(memEn), 32'd0);
    @(negedge clk);
    check("b2b_idle_busy", 32'(reqBusy), 32'd0);
    check("b2b_idle_memEn", 32'(memEn), 32'd0);
    @(negedge clk);
    reqValid = 1'b0;
    check("b2b_second_memEn", 32'(memEn), 32'd1);
    check("b2b_second_addr", memAddr, 32'h500);
    check("b2b_second_wr", {memWrite, 27'd0, memBE}, {1'b1, 27'd0, 4'b1111});
    check("b2b_second_wdata", memWData, 32'h00000099);
    memReady = 1'b1;
    @(negedge clk);
    memReady = 1'b0;
    check("b2b_second_rsp", {rspValid, rspErr, 28'd0, rspOffset}, {1'b1, 1'b0, 28'd0, 2'b10});
    check("b2b_second_rdata", rspRData, 32'h0);
    @(negedge clk);
    check("tags_hold", {rspValid, 27'd0, rspExt, rspOffset, rspSize}, {1'b0, 27'd0, 1'b0, 2'b10, 2'b00});

    // Reset in the middle of an access aborts it without a response.
    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h600; reqSize = 2'b00;
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_memEn", 32'(memEn), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_memEn", 32'(memEn), 32'd0);
    check("rst_mid_busy", 32'(reqBusy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rspValid || memEn) seen++;
    end
    check("rst_no_rsp", seen, 0);
    r = mk_req(0, 32'h600, 32'h0, 2'b00, 0, 2, 32'h13579BDF);
    run_txn(r, o);
    compare_txn("post_rst", r, model(r), o);

    // Random requests against the lane model.
    for (int i = 0; i < 40; i++) begin
      r = mk_req($urandom_range(0, 1), $urandom, $urandom, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 1), $urandom_range(0, T + 2), $urandom);
      run_txn(r, o);
      compare_txn($sformatf("rnd%0d", i), r, model(r), o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
